// File: rtl/bcd_conv_sched.sv
// Shared binary-to-BCD conversion scheduler: round-robin grant over NCH requesters
// feeding one sequential shift-add-3 engine (one input bit per cycle, 6 BCD digits out).
module bcd_conv_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [NCH-1:0]    iREQ,
  input  logic [NCH*20-1:0] iBIN_BUS,
  output logic [NCH-1:0]    oACK,
  output logic              oBUSY,
  output logic              oVALID,
  output logic [CW-1:0]     oCH,
  output logic [23:0]       oBCD,
  output logic              oOVF
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   last, gidx, cur_ch;
  logic            found;
  logic [19:0]     cap_val;
  logic [19:0]     bin;
  logic [23:0]     digits, adj;
  logic [4:0]      cnt;
  logic            ovf;
  logic [NCH-1:0]  ack_nxt;
  logic            busy_nxt, valid_nxt;

  // Round-robin search upward from last+1, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && iREQ[(32'(last) + 32'd1 + i) % NCH]) begin
        found = 1'b1;
        gidx  = CW'((32'(last) + 32'd1 + i) % NCH);
      end
    end
  end

  assign cap_val = iBIN_BUS[20*int'(gidx) +: 20];

  always_comb begin
    adj = digits;
    for (int unsigned d = 0; d < 6; d++) begin
      if (digits[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = digits[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy also covers the cycle after DONE, where the registered oVALID strobe is visible.
  always_comb begin
    ack_nxt = '0;
    if (state == IDLE && found) ack_nxt[gidx] = 1'b1;
    busy_nxt  = (state_nxt != IDLE) || (state == DONE);
    valid_nxt = (state == DONE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oACK   <= '0;
      oBUSY  <= 1'b0;
      oVALID <= 1'b0;
      oCH    <= '0;
      oBCD   <= '0;
      oOVF   <= 1'b0;
      last   <= CW'(NCH - 1);
    end else begin
      oACK   <= ack_nxt;
      oBUSY  <= busy_nxt;
      oVALID <= valid_nxt;
      if (state == DONE) begin
        oCH  <= cur_ch;
        oBCD <= ovf ? 24'h999999 : digits;
        oOVF <= ovf;
        last <= cur_ch;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bin    <= '0;
      digits <= '0;
      cnt    <= '0;
      cur_ch <= '0;
      ovf    <= 1'b0;
    end else if (state == IDLE && found) begin
      bin    <= cap_val;
      digits <= '0;
      cnt    <= 5'd19;
      cur_ch <= gidx;
      ovf    <= (cap_val > 20'hF423F);
    end else if (state == SHIFT) begin
      {digits, bin} <= {adj, bin} << 1;
      if (cnt != '0) cnt <= cnt - 5'd1;
    end
  end

endmodule
